adder_seq: RTL and testbench

//  Parametrised multi-cycle adder. Computes s = a + b + cin over WIDTH bits,

---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/adder_chunk.sv | 17 +
 rtl/adder_seq.sv | 150 +++++++++++++++
 tb/tb_adder_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_seq_state_t;

    // Number of chunk additions needed to cover the whole operand width.
    function automatic int nstep(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// One CHUNK-bit slice of the ripple adder; purely combinational.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // Widen by one bit so the carry out of the slice falls into the top bit.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder: s = a + b + cin over WIDTH bits, CHUNK bits per clock,
// least significant chunk first, carry rippled between cycles through a register.
// Optional macro ADDER_SEQ_OVF_EN adds a signed-overflow output 'ovf'.
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef ADDER_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NSTEP  = nstep(WIDTH, CHUNK);
    localparam int STEP_W = $clog2(NSTEP + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    // Operands must split into whole chunks; anything else is a configuration error.
    generate
        if ((WIDTH % CHUNK) != 0) begin : gBadChunk
            $error("adder_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    adder_seq_state_t  state_q, state_d;
    logic [WIDTH-1:0]  aSh_q, aSh_d;
    logic [WIDTH-1:0]  bSh_q, bSh_d;
    logic [WIDTH-1:0]  sSh_q, sSh_d;
    logic              carry_q, carry_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [CHUNK-1:0]  chunkSum;
    logic              chunkCout;
    logic              accept;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) uChunk (
        .a    (aSh_q[CHUNK-1:0]),
        .b    (bSh_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (chunkSum),
        .cout (chunkCout)
    );

    assign accept = (state_q == IDLE) && in_valid;

    // State register, operand/result shift registers, carry and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sSh_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sSh_q   <= sSh_d;
            carry_q <= carry_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic: load on accept, add one chunk per RUN cycle, hold in DONE.
    // The sum chunk enters at the MSB end so after NSTEP steps it is in place.
    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sSh_d   = sSh_q;
        carry_d = carry_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d   = aSh_q >> CHUNK;
                bSh_d   = bSh_q >> CHUNK;
                sSh_d   = WIDTH'({chunkSum, sSh_q} >> CHUNK);
                carry_d = chunkCout;
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result and carry are read straight from the registers; out_valid qualifies them.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        s         = sSh_q;
        cout      = carry_q;
    end

`ifdef ADDER_SEQ_OVF_EN
    logic aSign_q;
    logic bSign_q;

    // Operand sign bits captured at accept, since the shift registers lose them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aSign_q <= 1'b0;
            bSign_q <= 1'b0;
        end else if (accept) begin
            aSign_q <= a[WIDTH-1];
            bSign_q <= b[WIDTH-1];
        end
    end

    // Signed overflow: like-signed operands producing a differently-signed sum.
    always_comb begin
        ovf = (aSign_q == bSign_q) && (sSh_q[WIDTH-1] != aSign_q);
    end
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq at WIDTH=16, CHUNK=4.
// Build with ADDER_SEQ_OVF_EN defined to also cover the overflow output.
module tb_adder_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NSTEP = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
`ifdef ADDER_SEQ_OVF_EN
    logic             ovf;
`endif

    int total;
    int bad;

    adder_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
`ifdef ADDER_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an operation is outstanding from its accept edge
    // until the edge where the consumer takes it; its result is the plain sum and
    // becomes visible NSTEP edges after acceptance.
    int               cyc;
    bit               haveOp;
    int               doneCyc;
    logic [WIDTH:0]   pendSum;
    bit               pendOvf;
    logic [WIDTH:0]   lastSum;
    bit               lastOvf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            haveOp  = 1'b0;
            lastSum = '0;
            lastOvf = 1'b0;
            doneCyc = 0;
        end else begin
            if (haveOp && (cyc >= doneCyc) && out_ready) begin
                haveOp  = 1'b0;
                lastSum = pendSum;
                lastOvf = pendOvf;
            end else if (!haveOp && in_valid) begin
                haveOp  = 1'b1;
                pendSum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                pendOvf = (a[WIDTH-1] == b[WIDTH-1]) && (pendSum[WIDTH-1] != a[WIDTH-1]);
                doneCyc = cyc + 1 + NSTEP;
            end
        end
        cyc++;
    end

    // Compare process: handshake flags every cycle, result whenever it is defined.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!haveOp));
            chk("busy", 32'(busy), 32'(haveOp));
            chk("out_valid", 32'(out_valid), 32'(haveOp && (cyc >= doneCyc)));
            if (haveOp && (cyc >= doneCyc)) begin
                chk("s", 32'(s), 32'(pendSum[WIDTH-1:0]));
                chk("cout", 32'(cout), 32'(pendSum[WIDTH]));
`ifdef ADDER_SEQ_OVF_EN
                chk("ovf", 32'(ovf), 32'(pendOvf));
`endif
            end else if (!haveOp) begin
                chk("s_idle", 32'(s), 32'(lastSum[WIDTH-1:0]));
                chk("cout_idle", 32'(cout), 32'(lastSum[WIDTH]));
`ifdef ADDER_SEQ_OVF_EN
                chk("ovf_idle", 32'(ovf), 32'(lastOvf));
`endif
            end
        end
    end

    // Offer one operand set and hold it until the accepting edge has passed.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vc);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result, pin it against literal expectations, optionally stall the
    // consumer while a new operand set is offered, then take the result.
    task automatic checkOutput(input logic [WIDTH-1:0] expS, input logic expC,
                               input logic expOvf, input int expLat, input int hold);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(expLat));
        chk("lit_s", 32'(s), 32'(expS));
        chk("lit_cout", 32'(cout), 32'(expC));
`ifdef ADDER_SEQ_OVF_EN
        chk("lit_ovf", 32'(ovf), 32'(expOvf));
`else
        if (expOvf === 1'bx) chk("ovf_arg", 32'(expOvf), 32'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 16'hAAAA;
            b        = 16'h5555;
            cin      = 1'b1;
            @(negedge clk);
            chk("hold_s", 32'(s), 32'(expS));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Runaway guard: never let the run hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a short randomised sweep.
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   rs;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h0000, 16'h0000, 1'b1);
        checkOutput(16'h0001, 1'b0, 1'b0, 4, 0);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput(16'h0000, 1'b1, 1'b0, 4, 0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput(16'hFFFF, 1'b1, 1'b0, 4, 0);

        // Consumer stalls five cycles while a new operand set waits at the input.
        applyStimulus(16'h0F0F, 16'h0101, 1'b0);
        checkOutput(16'h1010, 1'b0, 1'b0, 4, 5);
        repeat (3) @(negedge clk);
        chk("no_consume_busy", 32'(busy), 32'd0);
        chk("last_s_kept", 32'(s), 32'h1010);

        // Reset two steps into a computation discards it.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        checkOutput(16'h5555, 1'b0, 1'b0, 4, 0);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput(16'h8000, 1'b0, 1'b1, 4, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        checkOutput(16'h0000, 1'b1, 1'b1, 4, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput(16'h0000, 1'b1, 1'b0, 4, 0);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            applyStimulus(ra, rb, rc);
            checkOutput(rs[WIDTH-1:0], rs[WIDTH],
                        (ra[WIDTH-1] == rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]),
                        NSTEP, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
